// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic valid/ready register chain with an input skid entry and flush
module pipe_reg_chain #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 2,
    parameter int RESET_DATA = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [$clog2(DEPTH+2)-1:0]  occupancy
);
    localparam int OW = $clog2(DEPTH+2);

    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_adv;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic             r_sv;
    logic [WIDTH-1:0] r_sd;
    logic [OW-1:0]    r_occ;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_s0v;
    logic [WIDTH-1:0] w_s0d;

    assign in_ready   = ~r_sv & ~flush & ~reset;
    assign w_in_fire  = in_valid & in_ready;
    assign out_valid  = w_v[DEPTH-1];
    assign out_data   = w_d[DEPTH-1];
    assign w_out_fire = out_valid & out_ready;
    assign occupancy  = r_occ;
    // The skid entry is older than anything on the input, so it feeds stage 0 first
    assign w_s0v      = r_sv | w_in_fire;
    assign w_s0d      = r_sv ? r_sd : in_data;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             r_v;
        logic [WIDTH-1:0] r_d;
        logic             w_pv;
        logic [WIDTH-1:0] w_pd;
        // A stage may advance unless it and every stage downstream are full and the consumer stalls
        assign w_adv[k] = out_ready | ~(&w_v[DEPTH-1:k]);
        if (k == 0) begin : g_first
            assign w_pv = w_s0v;
            assign w_pd = w_s0d;
        end else begin : g_next
            assign w_pv = w_v[k-1];
            assign w_pd = w_d[k-1];
        end
        assign w_v[k] = r_v;
        assign w_d[k] = r_d;
        // Stage valid: cleared by reset or flush, otherwise follows the upstream valid on advance
        always_ff @(posedge clk) begin
            if (reset || flush) r_v <= 1'b0;
            else if (w_adv[k]) r_v <= w_pv;
        end
        // Stage payload: only captured when a valid entry moves in, so bubbles leave it untouched
        always_ff @(posedge clk) begin
            if (reset) begin
                if (RESET_DATA != 0) r_d <= '0;
            end else if (!flush && w_adv[k] && w_pv) r_d <= w_pd;
        end
    end

    // Skid valid: catches an accepted input when stage 0 cannot move, empties once it can
    always_ff @(posedge clk) begin
        if (reset || flush) r_sv <= 1'b0;
        else if (w_in_fire && !w_adv[0]) r_sv <= 1'b1;
        else if (w_adv[0]) r_sv <= 1'b0;
    end

    // Skid payload: captured together with the skid valid
    always_ff @(posedge clk) begin
        if (reset) begin
            if (RESET_DATA != 0) r_sd <= '0;
        end else if (w_in_fire && !w_adv[0]) r_sd <= in_data;
    end

    // Occupancy: running count of accepted minus delivered entries
    always_ff @(posedge clk) begin
        if (reset || flush) r_occ <= '0;
        else r_occ <= r_occ + OW'(w_in_fire) - OW'(w_out_fire);
    end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed and randomized checks of pipe_reg_chain at DEPTH 1, 2 and 4
module tb_pipe_reg_chain;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [2:0]  iv = '0;
    logic [2:0]  orr = '0;
    logic [31:0] id [3];
    wire  [2:0]  ir;
    wire  [2:0]  ov;
    wire  [31:0] od [3];
    wire  [2:0]  occ [3];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar n = 0; n < 3; n++) begin : g_dut
        localparam int D  = (n == 0) ? 1 : ((n == 1) ? 2 : 4);
        localparam int W  = (n == 0) ? 1 : 32;
        localparam int R  = (n == 1) ? 1 : 0;
        localparam int OW = $clog2(D+2);
        logic [W-1:0]  od_w;
        logic [OW-1:0] oc_w;
        logic          ir_w;
        logic          ov_w;
        pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_DATA(R)) u_dut (
            .clk(clk), .reset(reset), .flush(flush),
            .in_valid(iv[n]), .in_ready(ir_w), .in_data(id[n][W-1:0]),
            .out_valid(ov_w), .out_ready(orr[n]), .out_data(od_w), .occupancy(oc_w)
        );
        assign ir[n]  = ir_w;
        assign ov[n]  = ov_w;
        assign od[n]  = 32'(od_w);
        assign occ[n] = 3'(oc_w);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill3(input logic [31:0] base);
        orr[1] = 1'b0;
        iv[1] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            id[1] = base + 32'(j);
            tick();
        end
        iv[1] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        iv = '0;
        orr = '0;
        for (int n = 0; n < 3; n++) id[n] = '0;
        tick();
        tick();
        checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL reset_ov got %0b exp 0", ov[1]); end
        checks++; if (occ[1] !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occ[1]); end
        checks++; if (od[1] !== 32'h0) begin errors++; $display("FAIL reset_data got %0h exp 0", od[1]); end
        checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL reset_ready_held got %0b exp 0", ir[1]); end
        reset = 1'b0;
        #1;
        checks++; if (ir[1] !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %0b exp 1", ir[1]); end
    endtask

    task automatic test_single();
        orr[1] = 1'b1;
        iv[1] = 1'b1;
        id[1] = 32'hA5;
        tick();
        iv[1] = 1'b0;
        checks++; if (ov[1] !== 1'b0 || occ[1] !== 3'd1) begin errors++; $display("FAIL single_e1 got ov %0b occ %0d exp ov 0 occ 1", ov[1], occ[1]); end
        tick();
        checks++; if (ov[1] !== 1'b1 || od[1] !== 32'hA5) begin errors++; $display("FAIL single_e2 got ov %0b data %0h exp ov 1 data a5", ov[1], od[1]); end
        tick();
        checks++; if (ov[1] !== 1'b0 || occ[1] !== 3'd0) begin errors++; $display("FAIL single_e3 got ov %0b occ %0d exp ov 0 occ 0", ov[1], occ[1]); end
    endtask

    task automatic test_stream();
        logic       eov;
        logic [2:0] eocc;
        orr[1] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            iv[1] = (c <= 10);
            id[1] = 32'(c - 1);
            tick();
            eov  = (c >= 2) && (c <= 11);
            eocc = (c == 1) ? 3'd1 : (c <= 10) ? 3'd2 : (c == 11) ? 3'd1 : 3'd0;
            checks++; if (ov[1] !== eov) begin errors++; $display("FAIL stream_valid c=%0d got %0b exp %0b", c, ov[1], eov); end
            if (eov) begin
                checks++; if (od[1] !== 32'(c - 2)) begin errors++; $display("FAIL stream_data c=%0d got %0h exp %0h", c, od[1], c - 2); end
            end
            checks++; if (occ[1] !== eocc) begin errors++; $display("FAIL stream_occ c=%0d got %0d exp %0d", c, occ[1], eocc); end
        end
        iv[1] = 1'b0;
    endtask

    task automatic test_full_drain();
        fill3(32'd1);
        checks++; if (ov[1] !== 1'b1 || od[1] !== 32'd1) begin errors++; $display("FAIL full_head got ov %0b data %0h exp ov 1 data 1", ov[1], od[1]); end
        checks++; if (occ[1] !== 3'd3) begin errors++; $display("FAIL full_occ got %0d exp 3", occ[1]); end
        checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", ir[1]); end
        orr[1] = 1'b1;
        tick();
        checks++; if (od[1] !== 32'd2 || occ[1] !== 3'd2 || ir[1] !== 1'b1) begin errors++; $display("FAIL drain_1 got data %0h occ %0d ready %0b exp 2 2 1", od[1], occ[1], ir[1]); end
        tick();
        checks++; if (ov[1] !== 1'b1 || od[1] !== 32'd3 || occ[1] !== 3'd1) begin errors++; $display("FAIL drain_2 got ov %0b data %0h occ %0d exp 1 3 1", ov[1], od[1], occ[1]); end
        tick();
        checks++; if (ov[1] !== 1'b0 || occ[1] !== 3'd0) begin errors++; $display("FAIL drain_3 got ov %0b occ %0d exp 0 0", ov[1], occ[1]); end
    endtask

    task automatic test_flush();
        fill3(32'd4);
        flush = 1'b1;
        iv[1] = 1'b1;
        id[1] = 32'h77;
        #1;
        checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", ir[1]); end
        checks++; if (ov[1] !== 1'b1 || od[1] !== 32'd4) begin errors++; $display("FAIL flush_preview got ov %0b data %0h exp 1 4", ov[1], od[1]); end
        tick();
        flush = 1'b0;
        iv[1] = 1'b0;
        #1;
        checks++; if (ov[1] !== 1'b0 || occ[1] !== 3'd0 || ir[1] !== 1'b1) begin errors++; $display("FAIL flush_after got ov %0b occ %0d ready %0b exp 0 0 1", ov[1], occ[1], ir[1]); end
        orr[1] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (ov[1] !== 1'b0) begin errors++; $display("FAIL flush_leak c=%0d got ov %0b data %0h exp ov 0", c, ov[1], od[1]); end
        end
    endtask

    task automatic test_reset_mid();
        fill3(32'h11);
        reset = 1'b1;
        #1;
        checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL rmid_ready_pre got %0b exp 0", ir[1]); end
        tick();
        checks++; if (ov[1] !== 1'b0 || occ[1] !== 3'd0) begin errors++; $display("FAIL rmid_state got ov %0b occ %0d exp 0 0", ov[1], occ[1]); end
        checks++; if (od[1] !== 32'h0) begin errors++; $display("FAIL rmid_data got %0h exp 0", od[1]); end
        tick();
        checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL rmid_ready_held got %0b exp 0", ir[1]); end
        reset = 1'b0;
        #1;
        checks++; if (ir[1] !== 1'b1) begin errors++; $display("FAIL rmid_ready_after got %0b exp 1", ir[1]); end
    endtask

    task automatic test_random();
        int          pushed [3];
        int          popped [3];
        logic [2:0]  fi;
        logic [2:0]  fo;
        logic [31:0] exp_d;
        logic [31:0] mask;
        for (int n = 0; n < 3; n++) begin
            pushed[n] = 0;
            popped[n] = 0;
        end
        for (int c = 0; c < 560; c++) begin
            for (int n = 0; n < 3; n++) begin
                if (!iv[n]) begin
                    iv[n] = (c < 500) ? 1'($urandom_range(0, 1)) : 1'b0;
                    id[n] = 32'(pushed[n]);
                end
                orr[n] = (c < 500) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #1;
            for (int n = 0; n < 3; n++) begin
                fi[n] = iv[n] & ir[n];
                fo[n] = ov[n] & orr[n];
                mask  = (n == 0) ? 32'h1 : 32'hFFFF_FFFF;
                exp_d = 32'(popped[n]) & mask;
                if (ov[n]) begin
                    checks++; if (od[n] !== exp_d || popped[n] >= pushed[n]) begin errors++; $display("FAIL rand_data n=%0d c=%0d got %0h exp %0h (pushed %0d popped %0d)", n, c, od[n], exp_d, pushed[n], popped[n]); end
                end
            end
            tick();
            for (int n = 0; n < 3; n++) begin
                if (fi[n]) begin
                    pushed[n]++;
                    iv[n] = 1'b0;
                end
                if (fo[n]) popped[n]++;
                checks++; if (occ[n] !== 3'(pushed[n] - popped[n])) begin errors++; $display("FAIL rand_occ n=%0d c=%0d got %0d exp %0d", n, c, occ[n], pushed[n] - popped[n]); end
            end
        end
        for (int n = 0; n < 3; n++) begin
            checks++; if (popped[n] !== pushed[n] || pushed[n] < 50) begin errors++; $display("FAIL rand_total n=%0d got popped %0d exp pushed %0d", n, popped[n], pushed[n]); end
        end
    endtask

    initial begin
        for (int n = 0; n < 3; n++) id[n] = '0;
        #1;
        test_reset();
        test_single();
        test_stream();
        test_full_drain();
        test_flush();
        test_reset_mid();
        test_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
